// File: rtl/msg_arbiter2.sv
// msg_arbiter2: two-channel round-robin message arbiter with 4-phase
// req/ack handshakes on both sides and a one-message holding register.
// Raw handshake inputs are debounced by msg_arbiter2_chk before use.

// Level checker: the checked level follows the raw input only after the
// raw input has disagreed with it for CKS consecutive clock edges.
module msg_arbiter2_chk #(
    parameter int CKS = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic lvl_o
);
    localparam int CW = $clog2(CKS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;

    // Next-state: count consecutive disagreements, flip the level on the CKS-th one
    always_comb begin
        cnt_d = {CW{1'b0}};
        lvl_d = lvl_q;
        if (raw_i == lvl_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CW'(CKS - 1)) begin
            lvl_d = raw_i;
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Checker state register with synchronous reset to a low level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CW{1'b0}};
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign lvl_o = lvl_q;
endmodule

module msg_arbiter2 #(
    parameter int ASZ     = 6,
    parameter int DSZ     = 4,
    parameter int RSZ     = 4,
    parameter int REQ_CKS = 2,
    parameter int ACK_CKS = 2
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,
    input  logic [ASZ-1:0] rcv0_addr,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv0_req,
    output logic           rcv0_ack_out,
    input  logic [ASZ-1:0] rcv1_addr,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,
    input  logic           rcv1_req,
    output logic           rcv1_ack_out,
    output logic [ASZ-1:0] snd0_addr,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req_out,
    input  logic           snd0_ack
);
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SEND  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           ready_q, ready_d;
    logic           last_q, last_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           sreq_q, sreq_d;
    logic [ASZ-1:0] addr_q, addr_d;
    logic [DSZ-1:0] dat_q, dat_d;
    logic [RSZ-1:0] red_q, red_d;

    logic req0_lvl_s, req1_lvl_s, ack_lvl_s;
    logic elig0_s, elig1_s, grant0_s, grant1_s;

    msg_arbiter2_chk #(.CKS(REQ_CKS)) u_chk_req0 (
        .clk_i(gch_clk), .rst_i(gch_reset), .raw_i(rcv0_req), .lvl_o(req0_lvl_s));
    msg_arbiter2_chk #(.CKS(REQ_CKS)) u_chk_req1 (
        .clk_i(gch_clk), .rst_i(gch_reset), .raw_i(rcv1_req), .lvl_o(req1_lvl_s));
    msg_arbiter2_chk #(.CKS(ACK_CKS)) u_chk_ack (
        .clk_i(gch_clk), .rst_i(gch_reset), .raw_i(snd0_ack), .lvl_o(ack_lvl_s));

    // A requester whose ack is still high has not finished its handshake and
    // must not be captured twice. On a tie the pointer hands the grant to
    // the requester that was not served last.
    assign elig0_s  = req0_lvl_s & ~ack0_q;
    assign elig1_s  = req1_lvl_s & ~ack1_q;
    assign grant0_s = elig0_s & (~elig1_s | last_q);
    assign grant1_s = elig1_s & (~elig0_s | ~last_q);

    // Next-state and output logic for the arbitration FSM and holding register
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        last_d  = last_q;
        ack0_d  = ack0_q;
        ack1_d  = ack1_q;
        sreq_d  = sreq_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        red_d   = red_q;

        // Requester acks drop as soon as the checked req goes low, in any state
        if (ack0_q && !req0_lvl_s) begin
            ack0_d = 1'b0;
        end else begin
            ack0_d = ack0_q;
        end
        if (ack1_q && !req1_lvl_s) begin
            ack1_d = 1'b0;
        end else begin
            ack1_d = ack1_q;
        end

        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            ST_IDLE: begin
                if (grant0_s) begin
                    addr_d  = rcv0_addr;
                    dat_d   = rcv0_dat;
                    red_d   = rcv0_red;
                    ack0_d  = 1'b1;
                    sreq_d  = 1'b1;
                    last_d  = 1'b0;
                    state_d = ST_SEND;
                end else if (grant1_s) begin
                    addr_d  = rcv1_addr;
                    dat_d   = rcv1_dat;
                    red_d   = rcv1_red;
                    ack1_d  = 1'b1;
                    sreq_d  = 1'b1;
                    last_d  = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (ack_lvl_s) begin
                    sreq_d  = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DRAIN: begin
                if (!ack_lvl_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and output registers; reset drops any held message and all handshakes
    always_ff @(posedge gch_clk) begin
        if (gch_reset) begin
            state_q <= ST_INIT;
            ready_q <= 1'b0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            sreq_q  <= 1'b0;
            addr_q  <= {ASZ{1'b0}};
            dat_q   <= {DSZ{1'b0}};
            red_q   <= {RSZ{1'b0}};
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            sreq_q  <= sreq_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            red_q   <= red_d;
        end
    end

    assign gch_ready    = ready_q;
    assign rcv0_ack_out = ack0_q;
    assign rcv1_ack_out = ack1_q;
    assign snd0_req_out = sreq_q;
    assign snd0_addr    = addr_q;
    assign snd0_dat     = dat_q;
    assign snd0_red     = red_q;
endmodule
